ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter: the sending end of the keyboard link, paired with the existing PS/2 receiver.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xF4 enable.
- Drives the open-collector clock and data lines through output-enable pins, clocks bits on device-generated clock edges, and checks the device ACK.
- Sits in the zxdos hps_io substitute. Its busy output gates the receiver's enable_rcv while a frame is in flight.

---
 rtl/ps2_host_tx.sv | 125 ++++++++++++
 tb/tb_ps2_host_tx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter that sends one command byte and checks the device ACK.
//   clk_sys, reset        : system clock, synchronous active-high reset
//   tx_data, tx_valid     : byte to send and request; accepted when tx_valid && tx_ready
//   tx_ready, busy        : idle / frame in flight
//   tx_done, tx_error     : one-cycle pulses for an ACKed frame / NACK or timeout
//   ps2clk_in, ps2data_in : raw open-collector line levels
//   ps2clk_oe, ps2data_oe : 1 pulls the corresponding line low
module ps2_host_tx #(
    parameter int CLK_KHZ     = 52000,
    parameter int INHIBIT_US  = 100,
    parameter int FIRST_TO_MS = 15,
    parameter int BIT_TO_MS   = 2,
    parameter int FILTER      = 8
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2clk_in,
    input  logic       ps2data_in,
    output logic       ps2clk_oe,
    output logic       ps2data_oe
);
    // Terminal timer values (count reaches N-1 on the N-th cycle)
    localparam logic [19:0] INH_L = 20'(CLK_KHZ * INHIBIT_US / 1000 - 1);
    localparam logic [19:0] T1_L  = 20'(CLK_KHZ * FIRST_TO_MS - 1);
    localparam logic [19:0] TB_L  = 20'(CLK_KHZ * BIT_TO_MS - 1);
    localparam int FW = $clog2(FILTER + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, WAITIDLE, ERROR} state_t;

    state_t state, state_n;
    logic [1:0] clk_sync, dat_sync;
    logic [FW-1:0] clk_cnt, dat_cnt;
    logic clk_filt, dat_filt, clk_prev, fall;
    logic [19:0] timer;
    logic [9:0] sh;
    logic [3:0] cnt;
    logic dq;

    // A new level is accepted only after FILTER consecutive differing samples
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_filt <= 1'b1;
            dat_filt <= 1'b1;
            clk_prev <= 1'b1;
            clk_cnt  <= '0;
            dat_cnt  <= '0;
        end else begin
            clk_sync <= {clk_sync[0], ps2clk_in};
            dat_sync <= {dat_sync[0], ps2data_in};
            clk_prev <= clk_filt;
            if (clk_sync[1] == clk_filt)
                clk_cnt <= '0;
            else if (clk_cnt == FW'(FILTER - 1)) begin
                clk_filt <= clk_sync[1];
                clk_cnt  <= '0;
            end else
                clk_cnt <= clk_cnt + 1'b1;
            if (dat_sync[1] == dat_filt)
                dat_cnt <= '0;
            else if (dat_cnt == FW'(FILTER - 1)) begin
                dat_filt <= dat_sync[1];
                dat_cnt  <= '0;
            end else
                dat_cnt <= dat_cnt + 1'b1;
        end
    end

    assign fall = clk_prev & ~clk_filt;

    always_ff @(posedge clk_sys) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = tx_valid ? INHIBIT : IDLE;
            INHIBIT:  state_n = (timer == INH_L) ? RTS : INHIBIT;
            RTS:      state_n = fall ? SHIFT : (timer == T1_L) ? ERROR : RTS;
            SHIFT:    state_n = (fall && cnt == 4'd10) ? (dat_filt ? ERROR : WAITIDLE) :
                                (!fall && timer == TB_L) ? ERROR : SHIFT;
            WAITIDLE: state_n = (clk_filt && dat_filt) ? IDLE : (timer == TB_L) ? ERROR : WAITIDLE;
            default:  state_n = IDLE;
        endcase
    end

    // Timer restarts on every state change and on each device edge while shifting
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            timer <= '0;
            sh    <= '0;
            cnt   <= '0;
            dq    <= 1'b0;
        end else begin
            timer <= (state_n != state || (state == SHIFT && fall)) ? '0 : timer + 1'b1;
            if (state == IDLE && tx_valid)
                sh <= {1'b1, ~^tx_data, tx_data};
            else if (fall && (state == RTS || (state == SHIFT && cnt != 4'd10))) begin
                dq  <= ~sh[0];
                sh  <= {1'b1, sh[9:1]};
                cnt <= (state == RTS) ? 4'd1 : cnt + 1'b1;
            end
        end
    end

    always_comb begin
        tx_ready   = state == IDLE;
        busy       = state != IDLE;
        ps2clk_oe  = state == INHIBIT;
        ps2data_oe = (state == INHIBIT && timer == INH_L) || state == RTS || (state == SHIFT && dq);
        tx_done    = state == WAITIDLE && clk_filt && dat_filt;
        tx_error   = state == ERROR;
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with an open-collector PS/2 device model.
module tb_ps2_host_tx;
    localparam int H   = 40;
    localparam int INH = 100;
    localparam int T1  = 3000;
    localparam int TB  = 1000;

    logic clk_sys = 1'b0;
    logic reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic tx_valid = 1'b0;
    logic tx_ready, tx_done, tx_error, busy, ps2clk_oe, ps2data_oe;
    logic ps2clk_in, ps2data_in;
    logic dev_clk = 1'b0;
    logic dev_dat = 1'b0;

    assign ps2clk_in  = ~(ps2clk_oe | dev_clk);
    assign ps2data_in = ~(ps2data_oe | dev_dat);

    ps2_host_tx #(
        .CLK_KHZ(1000), .INHIBIT_US(100), .FIRST_TO_MS(3), .BIT_TO_MS(1), .FILTER(8)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_done(tx_done), .tx_error(tx_error), .busy(busy),
        .ps2clk_in(ps2clk_in), .ps2data_in(ps2data_in),
        .ps2clk_oe(ps2clk_oe), .ps2data_oe(ps2data_oe)
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad = 0;
    int n_done = 0, n_err = 0, n_oe = 0, n_acc = 0;
    logic err_prev = 1'b0;

    always @(posedge clk_sys) begin
        if (tx_done) n_done <= n_done + 1;
        if (tx_error) n_err <= n_err + 1;
        if (ps2clk_oe) n_oe <= n_oe + 1;
        if (tx_valid && tx_ready && !reset) n_acc <= n_acc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lines must be released the cycle after an error pulse; done and error never coincide
    always @(negedge clk_sys) begin
        if (err_prev) chk("oe_after_err", {30'd0, ps2clk_oe, ps2data_oe}, 0);
        if (tx_done || tx_error) chk("done_err_excl", {31'd0, tx_done & tx_error}, 0);
        err_prev <= tx_error;
    end

    task automatic send(input logic [7:0] d);
        @(negedge clk_sys);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk_sys);
        tx_valid = 1'b0;
        chk("ready_drop", {31'd0, tx_ready}, 0);
    endtask

    // Device: waits for request-to-send, samples data at the end of each high phase, then clocks.
    task automatic dev_frame(input bit ack, input int last, input int glitch,
                             output logic [10:0] bits, output bit busy_ok);
        int t = 0;
        bits = '0;
        busy_ok = 1'b1;
        while (!(ps2data_oe && !ps2clk_oe) && t < 5000) begin
            @(negedge clk_sys);
            t++;
        end
        chk("rts_seen", {31'd0, t < 5000}, 1);
        if (t >= 5000) return;
        repeat (20) @(negedge clk_sys);
        for (int e = 1; e <= last; e++) begin
            if (e == glitch) begin
                repeat (H / 2) @(negedge clk_sys);
                dev_clk = 1'b1;
                repeat (3) @(negedge clk_sys);
                dev_clk = 1'b0;
                repeat (H / 2 - 3) @(negedge clk_sys);
            end else
                repeat (H) @(negedge clk_sys);
            bits[e-1] = ps2data_in;
            if (!busy) busy_ok = 1'b0;
            if (e == 11 && ack) begin
                dev_dat = 1'b1;
                repeat (5) @(negedge clk_sys);
            end
            dev_clk = 1'b1;
            repeat (H) @(negedge clk_sys);
            dev_clk = 1'b0;
        end
        if (last == 11) begin
            repeat (H) @(negedge clk_sys);
            dev_dat = 1'b0;
        end
    endtask

    task automatic wait_end();
        int t = 0;
        while (!(tx_done || tx_error) && t < 20000) begin
            @(negedge clk_sys);
            t++;
        end
        tx_valid = 1'b0;
        chk("end_in_time", {31'd0, t < 20000}, 1);
    endtask

    initial begin
        logic [10:0] bits;
        bit bok;
        int d0, e0, o0, a0, n;
        repeat (5) @(negedge clk_sys);
        chk("rst_ready", {31'd0, tx_ready}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_pulses", {30'd0, tx_done, tx_error}, 0);
        chk("rst_oe", {30'd0, ps2clk_oe, ps2data_oe}, 0);
        reset = 1'b0;
        repeat (20) @(negedge clk_sys);

        // 0xED with ACK
        d0 = n_done; e0 = n_err; o0 = n_oe;
        send(8'hED);
        dev_frame(1'b1, 11, 0, bits, bok);
        wait_end();
        chk("ed_done_pulse", {31'd0, tx_done}, 1);
        chk("ed_bits", {21'd0, bits}, 32'b111_1101_1010);
        chk("ed_busy", {31'd0, bok}, 1);
        @(negedge clk_sys);
        chk("ed_ready_back", {31'd0, tx_ready}, 1);
        chk("ed_done_cnt", n_done - d0, 1);
        chk("ed_err_cnt", n_err - e0, 0);
        chk("ed_inhibit_len", n_oe - o0, INH);

        // 0xF4, tx_data changed after acceptance
        d0 = n_done; e0 = n_err;
        send(8'hF4);
        tx_data = 8'h00;
        dev_frame(1'b1, 11, 0, bits, bok);
        wait_end();
        @(negedge clk_sys);
        chk("f4_bits", {21'd0, bits}, 32'b101_1110_1000);
        chk("f4_done_cnt", n_done - d0, 1);
        chk("f4_err_cnt", n_err - e0, 0);

        // NACK: device leaves data high at edge 11
        d0 = n_done; e0 = n_err;
        send(8'hA5);
        dev_frame(1'b0, 11, 0, bits, bok);
        repeat (10) @(negedge clk_sys);
        chk("nack_bits", {21'd0, bits}, 32'b111_0100_1010);
        chk("nack_err_cnt", n_err - e0, 1);
        chk("nack_done_cnt", n_done - d0, 0);
        chk("nack_ready", {31'd0, tx_ready}, 1);

        // Device never clocks: error exactly T1 cycles after RTS entry
        e0 = n_err;
        send(8'hF4);
        n = 0;
        while (!(ps2data_oe && !ps2clk_oe) && n < 5000) begin
            @(negedge clk_sys);
            n++;
        end
        n = 0;
        while (!tx_error && n < 10000) begin
            @(negedge clk_sys);
            n++;
        end
        chk("t1_timeout", n, T1);
        @(negedge clk_sys);
        chk("t1_err_cnt", n_err - e0, 1);

        // Device stops after edge 5: error about TB after that edge
        d0 = n_done; e0 = n_err;
        send(8'hF4);
        dev_frame(1'b1, 5, 0, bits, bok);
        n = 0;
        while (!tx_error && n < 5000) begin
            @(negedge clk_sys);
            n++;
        end
        chk("tb_timeout_window", {31'd0, n >= TB - H && n <= TB - H + 20}, 1);
        @(negedge clk_sys);
        chk("tb_released", {30'd0, ps2clk_oe, ps2data_oe}, 0);
        chk("tb_done_cnt", n_done - d0, 0);

        // Reset during SHIFT after edge 4 (bit3 of 0x00 is 0, so data is pulled)
        d0 = n_done; e0 = n_err;
        send(8'h00);
        dev_frame(1'b1, 4, 0, bits, bok);
        chk("rst_mid_pre", {31'd0, ps2data_oe}, 1);
        reset = 1'b1;
        @(negedge clk_sys);
        chk("rst_mid_oe", {30'd0, ps2clk_oe, ps2data_oe}, 0);
        chk("rst_mid_ready", {31'd0, tx_ready}, 1);
        reset = 1'b0;
        repeat (30) @(negedge clk_sys);
        chk("rst_mid_pulses", (n_done - d0) + (n_err - e0), 0);

        // tx_valid held high during the frame: exactly one frame
        d0 = n_done; a0 = n_acc;
        @(negedge clk_sys);
        tx_data  = 8'hF4;
        tx_valid = 1'b1;
        dev_frame(1'b1, 11, 0, bits, bok);
        wait_end();
        repeat (200) @(negedge clk_sys);
        chk("hold_acc_cnt", n_acc - a0, 1);
        chk("hold_done_cnt", n_done - d0, 1);
        chk("hold_idle", {30'd0, tx_ready, busy}, 2'b10);

        // 3-cycle clock glitch between edges 3 and 4 is ignored
        d0 = n_done; e0 = n_err;
        send(8'hED);
        dev_frame(1'b1, 11, 4, bits, bok);
        wait_end();
        @(negedge clk_sys);
        chk("glitch_bits", {21'd0, bits}, 32'b111_1101_1010);
        chk("glitch_done_cnt", n_done - d0, 1);
        chk("glitch_err_cnt", n_err - e0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
